// File: rtl/dma_stream_src_pkg.sv
// Shared definitions for the DMA push path: FSM encoding and address/burst sizing
// used by the stream source, the endpoint and the register block.
package dma_stream_src_pkg;

    localparam int DW_ADDR_W  = 30;
    localparam int TLP_DW_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_XFER,
        ST_GAP
    } dma_state_e;

endpackage

// File: rtl/dma_stream_src.sv
// Drains an FWFT FIFO in fixed-size write-TLP bursts over a circular host buffer,
// raising an interrupt pulse at the half-buffer and end-of-buffer points.
module dma_stream_src
    import dma_stream_src_pkg::*;
#(
    parameter int TLP_DW     = TLP_DW_DEF,
    parameter int CNT_W      = 16,
    parameter int FIFO_CNT_W = 12
) (
    input  logic                  trn_clk_c,
    input  logic                  pio_reset_n,
    input  logic                  dma_enable,
    input  logic [DW_ADDR_W-1:0]  buf_base_addr,
    input  logic [CNT_W-1:0]      buf_len_tlp,
    input  logic [31:0]           fifo_dout,
    input  logic [FIFO_CNT_W-1:0] fifo_count,
    output logic                  fifo_rd_en,
    output logic [DW_ADDR_W-1:0]  dma_addr,
    output logic [31:0]           dma_data,
    output logic                  dma_start,
    input  logic                  dma_rd_en,
    output logic                  start_int_o,
    output logic [CNT_W-1:0]      tlp_idx_o,
    output logic                  proto_err_o
);

    localparam int WC_W = (TLP_DW > 1) ? $clog2(TLP_DW) : 1;

    dma_state_e           state_q;
    logic [DW_ADDR_W-1:0] base_q;
    logic [DW_ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]     len_q;
    logic [CNT_W-1:0]     tlp_idx_q;
    logic [CNT_W-1:0]     tlp_idx_d;
    logic [WC_W-1:0]      wcnt_q;
    logic                 en_q;
    logic                 start_q;
    logic                 int_q;
    logic                 err_q;
    logic                 last_word;
    logic                 fifo_ready;

    assign dma_data    = fifo_dout;
    assign fifo_rd_en  = dma_rd_en & (state_q == ST_XFER);
    assign dma_addr    = addr_q;
    assign dma_start   = start_q;
    assign start_int_o = int_q;
    assign tlp_idx_o   = tlp_idx_q;
    assign proto_err_o = err_q;

    assign tlp_idx_d  = tlp_idx_q + CNT_W'(1);
    assign last_word  = (wcnt_q == WC_W'(TLP_DW - 1));
    assign fifo_ready = (fifo_count >= FIFO_CNT_W'(TLP_DW));

    // en_q resets high so an enable already held across reset is not seen as an edge.
    always_ff @(posedge trn_clk_c or negedge pio_reset_n) begin
        if (!pio_reset_n) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            tlp_idx_q <= '0;
            wcnt_q    <= '0;
            en_q      <= 1'b1;
            start_q   <= 1'b0;
            int_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            en_q  <= dma_enable;
            int_q <= 1'b0;
            if (dma_rd_en && (state_q != ST_XFER))
                err_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (dma_enable && !en_q) begin
                        base_q    <= buf_base_addr;
                        addr_q    <= buf_base_addr;
                        len_q     <= buf_len_tlp;
                        tlp_idx_q <= '0;
                        wcnt_q    <= '0;
                        state_q   <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (!dma_enable) begin
                        state_q <= ST_IDLE;
                    end else if (fifo_ready) begin
                        start_q <= 1'b1;
                        state_q <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    // A started TLP always runs to completion, even if enable drops.
                    if (dma_rd_en) begin
                        wcnt_q <= last_word ? '0 : wcnt_q + WC_W'(1);
                        if (last_word) begin
                            start_q <= 1'b0;
                            state_q <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    state_q <= ST_ARM;
                    if (tlp_idx_d == (len_q >> 1)) begin
                        int_q     <= 1'b1;
                        tlp_idx_q <= tlp_idx_d;
                        addr_q    <= addr_q + DW_ADDR_W'(TLP_DW);
                    end else if (tlp_idx_d == len_q) begin
                        int_q     <= 1'b1;
                        tlp_idx_q <= '0;
                        addr_q    <= base_q;
                    end else begin
                        tlp_idx_q <= tlp_idx_d;
                        addr_q    <= addr_q + DW_ADDR_W'(TLP_DW);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_stream_src.sv
// Directed bench for dma_stream_src: behavioural FWFT FIFO plus a throttling endpoint.
module tb_dma_stream_src;

    logic        trn_clk_c = 1'b0;
    logic        pio_reset_n;
    logic        dma_enable;
    logic [29:0] buf_base_addr;
    logic [15:0] buf_len_tlp;
    logic [31:0] fifo_dout;
    logic [11:0] fifo_count;
    logic        fifo_rd_en;
    logic [29:0] dma_addr;
    logic [31:0] dma_data;
    logic        dma_start;
    logic        dma_rd_en;
    logic        start_int_o;
    logic [15:0] tlp_idx_o;
    logic        proto_err_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] fmem [0:511];
    int wp = 0;
    int rp = 0;
    int pop_cnt = 0;

    always #5 trn_clk_c = ~trn_clk_c;

    assign fifo_count = 12'(wp - rp);
    assign fifo_dout  = fmem[rp % 512];

    always @(posedge trn_clk_c)
        if (fifo_rd_en) begin
            rp      <= rp + 1;
            pop_cnt <= pop_cnt + 1;
        end

    dma_stream_src dut (
        .trn_clk_c     (trn_clk_c),
        .pio_reset_n   (pio_reset_n),
        .dma_enable    (dma_enable),
        .buf_base_addr (buf_base_addr),
        .buf_len_tlp   (buf_len_tlp),
        .fifo_dout     (fifo_dout),
        .fifo_count    (fifo_count),
        .fifo_rd_en    (fifo_rd_en),
        .dma_addr      (dma_addr),
        .dma_data      (dma_data),
        .dma_start     (dma_start),
        .dma_rd_en     (dma_rd_en),
        .start_int_o   (start_int_o),
        .tlp_idx_o     (tlp_idx_o),
        .proto_err_o   (proto_err_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            fmem[wp % 512] = 32'hC0DE_0000 + 32'(wp);
            wp++;
        end
    endtask

    task automatic wait_start(output bit ok);
        int n = 0;
        while (!dma_start && n < 20) begin
            @(negedge trn_clk_c);
            n++;
        end
        ok = dma_start;
        chk("start_timeout", {63'd0, dma_start}, 64'd1);
    endtask

    // Pops one full TLP, asserting dma_rd_en on every period-th cycle; ends in GAP.
    task automatic run_burst(input int period, input logic [29:0] exp_addr, input int stop_after);
        bit ok;
        int pops = 0;
        int k = 0;
        bit rd;
        bit addr_ok = 1;
        bit data_ok = 1;
        wait_start(ok);
        if (!ok) return;
        while (pops < 32 && k < 200) begin
            rd = ((k % period) == 0);
            dma_rd_en = rd;
            if (dma_addr !== exp_addr || dma_start !== 1'b1) addr_ok = 0;
            if (rd && dma_data !== fmem[rp % 512]) data_ok = 0;
            @(negedge trn_clk_c);
            k++;
            if (rd) pops++;
            if (pops == stop_after) dma_enable = 1'b0;
        end
        dma_rd_en = 1'b0;
        chk("burst_pops", 64'(pops), 64'd32);
        chk("burst_addr_stable", {63'd0, addr_ok}, 64'd1);
        chk("burst_data_order", {63'd0, data_ok}, 64'd1);
        chk("start_drop", {63'd0, dma_start}, 64'd0);
    endtask

    typedef struct {
        int          period;
        logic [29:0] addr;
        logic        intr;
        logic [15:0] idx;
        logic [29:0] nxt;
    } vec_t;

    vec_t vecs [4];
    int   p0;
    bit   ok;

    initial begin
        vecs[0] = '{1, 30'h0100_0000, 1'b0, 16'd1, 30'h0100_0020};
        vecs[1] = '{3, 30'h0100_0020, 1'b1, 16'd2, 30'h0100_0040};
        vecs[2] = '{1, 30'h0100_0040, 1'b0, 16'd3, 30'h0100_0060};
        vecs[3] = '{2, 30'h0100_0060, 1'b1, 16'd0, 30'h0100_0000};

        pio_reset_n   = 1'b0;
        dma_enable    = 1'b0;
        dma_rd_en     = 1'b0;
        buf_base_addr = 30'h0100_0000;
        buf_len_tlp   = 16'd4;
        repeat (3) @(negedge trn_clk_c);
        pio_reset_n = 1'b1;
        @(negedge trn_clk_c);

        chk("rst_start", {63'd0, dma_start}, 64'd0);
        chk("rst_addr", 64'(dma_addr), 64'd0);
        chk("rst_idx", 64'(tlp_idx_o), 64'd0);
        chk("rst_int", {63'd0, start_int_o}, 64'd0);
        chk("rst_err", {63'd0, proto_err_o}, 64'd0);
        chk("rst_rden", {63'd0, fifo_rd_en}, 64'd0);

        // Four bursts around a 4-TLP buffer
        push(128);
        dma_enable = 1'b1;
        for (int v = 0; v < 4; v++) begin
            run_burst(vecs[v].period, vecs[v].addr, -1);
            @(negedge trn_clk_c);
            chk($sformatf("v%0d_int", v), {63'd0, start_int_o}, {63'd0, vecs[v].intr});
            chk($sformatf("v%0d_idx", v), 64'(tlp_idx_o), 64'(vecs[v].idx));
            chk($sformatf("v%0d_next_addr", v), 64'(dma_addr), 64'(vecs[v].nxt));
        end
        @(negedge trn_clk_c);
        chk("int_one_cycle", {63'd0, start_int_o}, 64'd0);
        chk("pop_total", 64'(pop_cnt), 64'd128);

        // Threshold: 31 words holds in ARM, the 32nd launches
        dma_enable = 1'b0;
        @(negedge trn_clk_c);
        buf_base_addr = 30'h0200_0000;
        push(31);
        dma_enable = 1'b1;
        repeat (5) @(negedge trn_clk_c);
        chk("arm_hold_start", {63'd0, dma_start}, 64'd0);
        chk("arm_latched_addr", 64'(dma_addr), 64'h0200_0000);
        push(1);
        @(negedge trn_clk_c);
        chk("arm_launch", {63'd0, dma_start}, 64'd1);

        // Enable dropped after 10 pops: TLP completes, then IDLE
        p0 = pop_cnt;
        run_burst(1, 30'h0200_0000, 10);
        @(negedge trn_clk_c);
        chk("stop_idx", 64'(tlp_idx_o), 64'd1);
        chk("stop_pops", 64'(pop_cnt - p0), 64'd32);
        push(32);
        repeat (4) @(negedge trn_clk_c);
        chk("stop_idle_start", {63'd0, dma_start}, 64'd0);
        chk("stop_idle_idx", 64'(tlp_idx_o), 64'd1);
        chk("no_err_yet", {63'd0, proto_err_o}, 64'd0);

        // dma_rd_en outside XFER
        p0 = pop_cnt;
        dma_rd_en = 1'b1;
        #1;
        chk("idle_rden_blocked", {63'd0, fifo_rd_en}, 64'd0);
        @(negedge trn_clk_c);
        dma_rd_en = 1'b0;
        chk("err_set", {63'd0, proto_err_o}, 64'd1);
        repeat (3) @(negedge trn_clk_c);
        chk("err_sticky", {63'd0, proto_err_o}, 64'd1);
        chk("idle_no_pop", 64'(pop_cnt - p0), 64'd0);

        // Asynchronous reset mid-burst
        buf_base_addr = 30'h0300_0000;
        dma_enable = 1'b1;
        wait_start(ok);
        dma_rd_en = 1'b1;
        repeat (5) @(negedge trn_clk_c);
        dma_rd_en = 1'b0;
        #2 pio_reset_n = 1'b0;
        #1;
        chk("arst_start", {63'd0, dma_start}, 64'd0);
        chk("arst_addr", 64'(dma_addr), 64'd0);
        chk("arst_idx", 64'(tlp_idx_o), 64'd0);
        chk("arst_err", {63'd0, proto_err_o}, 64'd0);
        chk("arst_int", {63'd0, start_int_o}, 64'd0);
        @(negedge trn_clk_c);
        pio_reset_n = 1'b1;
        push(5);
        repeat (6) @(negedge trn_clk_c);
        chk("post_rst_no_burst", {63'd0, dma_start}, 64'd0);
        chk("post_rst_addr", 64'(dma_addr), 64'd0);
        dma_enable = 1'b0;
        @(negedge trn_clk_c);
        dma_enable = 1'b1;
        wait_start(ok);
        chk("rearm_addr", 64'(dma_addr), 64'h0300_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
